// File: rtl/avmm_csr_pkg.sv
// Shared definitions for the CSR command-to-Avalon-MM master: FSM states,
// timeout counter width and the default data returned on an aborted read.
package avmm_csr_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RSP     = 3'd4
    } state_t;

    localparam int unsigned CNT_W = 16;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/avmm_csr_master.sv
// Turns single CSR commands into Avalon-MM reads/writes, one outstanding at a
// time, with a per-transaction cycle budget that aborts unanswered accesses.
module avmm_csr_master
    import avmm_csr_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,

    output logic [31:0] master_address,
    output logic        master_read,
    output logic        master_write,
    output logic [31:0] master_writedata,
    output logic [3:0]  master_byteenable,
    input  logic        master_waitrequest,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,

    output logic        stray_rdv
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             expired;

    // A read accepted on its last budgeted cycle enters RD_WAIT with the
    // counter past the limit; >= makes that wait abort on its first cycle.
    assign expired           = (cnt_reg >= CNT_LAST);
    assign master_byteenable = 4'hF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            cmd_ready        <= 1'b0;
            master_read      <= 1'b0;
            master_write     <= 1'b0;
            master_address   <= '0;
            master_writedata <= '0;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= '0;
            rsp_timeout      <= 1'b0;
            stray_rdv        <= 1'b0;
        end else begin
            if (master_readdatavalid && (state_reg != RD_WAIT)) begin
                stray_rdv <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready        <= 1'b0;
                        cnt_reg          <= '0;
                        master_address   <= cmd_addr;
                        master_writedata <= cmd_wdata;
                        if (cmd_write) begin
                            master_write <= 1'b1;
                            state_reg    <= WR_REQ;
                        end else begin
                            master_read  <= 1'b1;
                            state_reg    <= RD_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    if (!master_waitrequest) begin
                        master_write <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= '0;
                        rsp_timeout  <= 1'b0;
                        state_reg    <= RSP;
                    end else if (expired) begin
                        master_write <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= ERR_RDATA;
                        rsp_timeout  <= 1'b1;
                        state_reg    <= RSP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                RD_REQ: begin
                    if (!master_waitrequest) begin
                        master_read <= 1'b0;
                        cnt_reg     <= cnt_reg + 1'b1;
                        state_reg   <= RD_WAIT;
                    end else if (expired) begin
                        master_read <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= ERR_RDATA;
                        rsp_timeout <= 1'b1;
                        state_reg   <= RSP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                RD_WAIT: begin
                    // Data arriving on the final budgeted cycle still wins.
                    if (master_readdatavalid) begin
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= master_readdata;
                        rsp_timeout <= 1'b0;
                        state_reg   <= RSP;
                    end else if (expired) begin
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= ERR_RDATA;
                        rsp_timeout <= 1'b1;
                        state_reg   <= RSP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg    <= IDLE;
                    master_read  <= 1'b0;
                    master_write <= 1'b0;
                    rsp_valid    <= 1'b0;
                    cmd_ready    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avmm_csr_master.sv
// Directed bench for avmm_csr_master: a scripted Avalon slave answers each
// command, expected responses are queued at issue and checked by a monitor.
module tb_avmm_csr_master;
    import avmm_csr_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] master_address, master_writedata, master_readdata;
    logic        master_read, master_write;
    logic [3:0]  master_byteenable;
    logic        master_waitrequest, master_readdatavalid;
    logic        stray_rdv;

    avmm_csr_master #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .master_address(master_address), .master_read(master_read),
        .master_write(master_write), .master_writedata(master_writedata),
        .master_byteenable(master_byteenable),
        .master_waitrequest(master_waitrequest),
        .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid),
        .stray_rdv(stray_rdv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        timeout;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Slave script
    int          slv_wait  = 0;
    int          slv_delay = 1;
    logic        slv_never = 1'b0;
    logic [31:0] slv_data  = '0;
    logic        force_rdv = 1'b0;

    // Monitor observations
    int          rsp_cnt = 0;
    int          rsp_first = -1;
    logic        rsp_valid_d = 1'b0;
    int          mw_run = 0, mr_run = 0, mw_len = 0, mr_len = 0;
    logic [31:0] mw_addr = '0, mw_data = '0, mr_addr = '0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scripted Avalon slave
    initial begin : slave
        int wcnt;
        int pend;
        wcnt = 0;
        pend = 0;
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
        forever begin
            @(posedge clk);
            #1;
            master_readdatavalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    master_readdatavalid = 1'b1;
                    master_readdata      = slv_data;
                end
            end
            if (force_rdv) begin
                master_readdatavalid = 1'b1;
                master_readdata      = 32'hBAD0_BAD0;
                force_rdv            = 1'b0;
            end
            if (master_read || master_write) begin
                if (wcnt < slv_wait) begin
                    master_waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    master_waitrequest = 1'b0;
                    wcnt = 0;
                    if (master_read && !slv_never) pend = slv_delay;
                end
            end else begin
                master_waitrequest = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Response monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (rsp_valid && !rsp_valid_d) rsp_first = cyc;
        rsp_valid_d = rsp_valid;
        if (master_write) begin
            mw_run++;
            mw_addr = master_address;
            mw_data = master_writedata;
        end else if (mw_run != 0) begin
            mw_len = mw_run;
            mw_run = 0;
        end
        if (master_read) begin
            mr_run++;
            mr_addr = master_address;
        end else if (mr_run != 0) begin
            mr_len = mr_run;
            mr_run = 0;
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual rdata=%h timeout=%b required none",
                         rsp_rdata, rsp_timeout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
                $display("rsp #%0d rdata=%h timeout=%b cycle=%0d",
                         rsp_cnt, rsp_rdata, rsp_timeout, cyc);
            end
            rsp_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int acc);
        acc       = -1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int k = 0; k < 50; k++) begin
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
            tick(1);
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout actual=no_accept required=accept");
        end
        tick(1);
        cmd_valid = 1'b0;
        $display("cmd write=%b addr=%h wdata=%h accepted cycle=%0d", w, a, d, acc);
    endtask

    task automatic wait_rsp(input int prev);
        for (int k = 0; k < 100; k++) begin
            if (rsp_cnt > prev) break;
            tick(1);
        end
        if (rsp_cnt <= prev) begin
            checks++;
            errors++;
            $display("FAIL rsp_wait_timeout actual=no_rsp required=rsp");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"},   32'(cmd_ready), 0);
        check({tag, "_master_read"}, 32'(master_read), 0);
        check({tag, "_master_write"}, 32'(master_write), 0);
        check({tag, "_master_address"}, master_address, 0);
        check({tag, "_master_writedata"}, master_writedata, 0);
        check({tag, "_rsp_valid"},   32'(rsp_valid), 0);
        check({tag, "_rsp_rdata"},   rsp_rdata, 0);
        check({tag, "_rsp_timeout"}, 32'(rsp_timeout), 0);
        check({tag, "_stray_rdv"},   32'(stray_rdv), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int acc;
        int prev;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;

        // Power-on reset
        #2;
        check_reset_outputs("por");
        check("byteenable", 32'(master_byteenable), 32'hF);
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("cmd_ready_after_release", 32'(cmd_ready), 1);

        // Zero-wait write: response two cycles after acceptance
        slv_wait = 0; slv_never = 1'b0;
        prev = rsp_cnt;
        exp_q.push_back('{32'h0000_0000, 1'b0});
        send(1'b1, 32'h0000_0010, 32'h1234_5678, acc);
        wait_rsp(prev);
        check("wr_latency", 32'(rsp_first - acc), 2);
        check("wr_pulse_len", 32'(mw_len), 1);
        check("wr_addr", mw_addr, 32'h0000_0010);
        check("wr_data", mw_data, 32'h1234_5678);
        check("cmd_ready_after_wr_rsp", 32'(cmd_ready), 1);

        // Read with 3 wait cycles, data 2 cycles after the slave accepts
        slv_wait = 3; slv_delay = 2; slv_data = 32'hCAFE_0001;
        prev = rsp_cnt;
        exp_q.push_back('{32'hCAFE_0001, 1'b0});
        send(1'b0, 32'h0000_0020, 32'h0, acc);
        wait_rsp(prev);
        check("rd_pulse_len", 32'(mr_len), 4);
        check("rd_addr", mr_addr, 32'h0000_0020);
        check("rd_latency", 32'(rsp_first - acc), 7);

        // Response backpressure held for 5 cycles
        slv_wait = 1; slv_delay = 1; slv_data = 32'hA5A5_0F0F;
        rsp_ready = 1'b0;
        prev = rsp_cnt;
        exp_q.push_back('{32'hA5A5_0F0F, 1'b0});
        send(1'b0, 32'h0000_0044, 32'h0, acc);
        for (int k = 0; k < 50; k++) begin
            if (rsp_valid) break;
            tick(1);
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 1);
            check("bp_rsp_rdata", rsp_rdata, 32'hA5A5_0F0F);
            check("bp_cmd_ready", 32'(cmd_ready), 0);
            tick(1);
        end
        rsp_ready = 1'b1;
        wait_rsp(prev);

        // readdatavalid on the last budgeted cycle: completion wins
        slv_wait = 0; slv_delay = TO - 1; slv_data = 32'h1357_9BDF;
        prev = rsp_cnt;
        exp_q.push_back('{32'h1357_9BDF, 1'b0});
        send(1'b0, 32'h0000_0030, 32'h0, acc);
        wait_rsp(prev);
        check("race_latency", 32'(rsp_first - acc), 9);

        // Unanswered read times out, later reply flagged as stray
        slv_wait = 1000;
        prev = rsp_cnt;
        exp_q.push_back('{32'hDEAD_BEEF, 1'b1});
        send(1'b0, 32'h0000_0050, 32'h0, acc);
        wait_rsp(prev);
        check("to_pulse_len", 32'(mr_len), TO);
        check("to_latency", 32'(rsp_first - acc), TO + 1);
        check("stray_before", 32'(stray_rdv), 0);
        force_rdv = 1'b1;
        tick(3);
        check("stray_after", 32'(stray_rdv), 1);
        tick(2);
        check("stray_sticky", 32'(stray_rdv), 1);

        // Reset while waiting for read data
        slv_wait = 0; slv_never = 1'b1;
        send(1'b0, 32'h0000_0060, 32'h0, acc);
        tick(2);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick(2);
        rst_n = 1'b1;
        prev = rsp_cnt;
        tick(1);
        check("cmd_ready_after_midrst", 32'(cmd_ready), 1);
        tick(20);
        check("no_rsp_after_reset", 32'(rsp_cnt), 32'(prev));
        check("rsp_valid_idle", 32'(rsp_valid), 0);
        check("exp_queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avmm_csr_master.md
AVMM_CSR_MASTER -- requirements
Module: avmm_csr_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning cycles allowed per transaction before abort (range 2..65535).
REQ-002 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, meaning rsp_rdata value returned on timeout.
REQ-003 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid  in  1  command request.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-007 SHALL have port cmd_write  in  1  1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr  in  32  CSR byte address.
REQ-009 SHALL have port cmd_wdata  in  32  write data.
REQ-010 SHALL have port rsp_valid  out  1  response available.
REQ-011 SHALL have port rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-012 SHALL have port rsp_rdata  out  32  read data; 0 for writes; ERR_RDATA on timeout.
REQ-013 SHALL have port rsp_timeout  out  1  response is a timeout abort.
REQ-014 SHALL have ports master_address out 32, master_read out 1, master_write out 1, master_writedata out 32, master_byteenable out 4: Avalon-MM request toward the CSR bridge.
REQ-015 SHALL have ports master_waitrequest in 1, master_readdata in 32, master_readdatavalid in 1: Avalon-MM response from the bridge.
REQ-016 SHALL have port stray_rdv  out  1  sticky flag: readdatavalid seen outside RD_WAIT.

Function
REQ-017 SHALL implement FSM states IDLE, WR_REQ, RD_REQ, RD_WAIT, RSP; one transaction outstanding at most.
REQ-018 SHALL drive cmd_ready = 1 only in IDLE; on acceptance, latch addr/wdata and go to WR_REQ (cmd_write=1) or RD_REQ (cmd_write=0).
REQ-019 SHALL assert registered master_write only in WR_REQ and master_read only in RD_REQ, with master_address/master_writedata stable the whole time asserted.
REQ-020 SHALL drive master_byteenable = 4'hF constantly.
REQ-021 SHALL hold the request while master_waitrequest = 1; WR_REQ with waitrequest = 0 -> RSP (rsp_rdata = 0); RD_REQ with waitrequest = 0 -> RD_WAIT.
REQ-022 SHALL in RD_WAIT capture master_readdata on master_readdatavalid = 1 into rsp_rdata and go to RSP; readdatavalid in the RD_REQ acceptance cycle is not sampled.
REQ-023 SHALL achieve a best-case latency of cmd accept at cycle N, master_write/read at N+1, rsp_valid at N+2 (write) or one cycle after readdatavalid (read).
REQ-024 SHALL hold rsp_valid and rsp_* stable in RSP until rsp_ready, then return to IDLE; cmd_ready rises the cycle after the handshake.
REQ-025 SHALL count cycles spent in WR_REQ, RD_REQ and RD_WAIT with a 16-bit counter cleared on command acceptance.
REQ-026 SHALL, when the counter reaches TIMEOUT_CYCLES-1 without completion, deassert master_read/master_write next cycle and enter RSP with rsp_timeout = 1 and rsp_rdata = ERR_RDATA.
REQ-027 SHALL give completion priority when completion and timeout occur in the same cycle: a normal response, rsp_timeout = 0.
REQ-028 SHALL set stray_rdv when master_readdatavalid = 1 in any state other than RD_WAIT (e.g. a late reply after timeout), ignore that data, and clear stray_rdv only by reset.

Reset
REQ-029 SHALL on rst_n = 0, immediately and asynchronously, force state IDLE, cmd_ready = 0 during reset (1 from the first clock after release), master_read = master_write = 0, master_address/master_writedata = 0, rsp_valid = 0, rsp_rdata = 0, rsp_timeout = 0, stray_rdv = 0, counter = 0.
REQ-030 SHALL abandon any in-flight transaction on reset mid-operation without issuing a response.

Structure
REQ-031 SHALL place the FSM state enum, the counter width (16) and the default ERR_RDATA constant in shared package avmm_csr_pkg.
REQ-032 SHALL be implemented as a single module with no sub-modules.

Verification
REQ-033 SHALL verify a write to 0x0000_0010 of data 0x1234_5678 with waitrequest = 0: master_write high for 1 cycle, rsp_valid at N+2, rsp_rdata = 0, rsp_timeout = 0.
REQ-034 SHALL verify a read of 0x0000_0020 with waitrequest held 3 cycles and readdatavalid 2 cycles after acceptance with data 0xCAFE_0001: master_read high for 4 cycles, then rsp_rdata = 0xCAFE_0001.
REQ-035 SHALL verify that with TIMEOUT_CYCLES = 8 and a read never answered, master_read drops after 8 cycles, rsp_timeout = 1 and rsp_rdata = 0xDEAD_BEEF; a later readdatavalid sets stray_rdv.
REQ-036 SHALL verify response backpressure: rsp_ready held low 5 cycles keeps rsp_valid/rsp_rdata stable and cmd_ready = 0 throughout.
REQ-037 SHALL verify that readdatavalid and timeout in the same cycle yield rsp_timeout = 0 with the captured data.
REQ-038 SHALL verify that rst_n asserted during RD_WAIT immediately drops all outputs to reset values, and no rsp_valid follows after release.
